puzzle_round_ctrl: RTL and testbench

Game sequencer for the 10-switch puzzle checker (is_correct/is_wrong/is_finish datapath).
- Steps the player through NUM_ROUNDS puzzles, using testcase codes 1..NUM_ROUNDS.
- Captures the switch pattern on submit and pulses the checker enable for one cycle.
- Tracks score, remaining tries and the per-round time limit, then reports win or lose.
- Sits between the board I/O (buttons, switches, LEDs) and the combinational checker.

---
 rtl/puzzle_pkg.sv | 35 +++
 rtl/btn_edge.sv | 25 ++
 rtl/puzzle_round_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_puzzle_round_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared types and constants for the puzzle game sequencer and its bench.
// Golden solutions mirror the combinational checker's answer table.
package puzzle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SUB,
    CHECK,
    RESULT,
    DONE
  } state_e;

  localparam logic [1:0] TC_NONE = 2'd0;

  localparam logic [9:0] SOL_TC1 = 10'h1AE;
  localparam logic [9:0] SOL_TC2 = 10'h261;
  localparam logic [9:0] SOL_TC3 = 10'h284;

  // A check only counts as solved when the checker is finished and unambiguous.
  function automatic logic check_passed(input logic correct, input logic wrong,
                                        input logic finish);
    return correct & ~wrong & finish;
  endfunction

  function automatic logic [9:0] golden_sol(input logic [1:0] tc);
    case (tc)
      2'd1:    return SOL_TC1;
      2'd2:    return SOL_TC2;
      2'd3:    return SOL_TC3;
      default: return 10'h3FF;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop rising-edge detector: turns a held button level into one
// registered single-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      pulse_q <= btn_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/puzzle_round_ctrl.sv
// Game sequencer for the 10-switch puzzle checker: rounds, tries, per-attempt
// time limit and win/lose reporting. Every output is a flop.
module puzzle_round_ctrl
  import puzzle_pkg::*;
#(
  parameter int NUM_ROUNDS  = 3,
  parameter int MAX_TRIES   = 3,
  parameter int TIME_LIMIT  = 1000,
  parameter int RESULT_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       submit,
  input  logic [9:0] switches,
  input  logic       chk_correct,
  input  logic       chk_wrong,
  input  logic       chk_finish,
  output logic       chk_en,
  output logic [1:0] chk_testcase,
  output logic [9:0] chk_sol,
  output logic [1:0] round_idx,
  output logic [1:0] score,
  output logic [2:0] tries_left,
  output logic       busy,
  output logic       res_ok,
  output logic       res_bad,
  output logic       game_over,
  output logic       win
);

  localparam int TIMER_W = $clog2(TIME_LIMIT);
  localparam int HOLD_W  = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIME_LIMIT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);
  localparam logic [1:0]         LAST_ROUND = 2'(NUM_ROUNDS - 1);
  localparam logic [2:0]         TRIES_INIT = 3'(MAX_TRIES);

  logic start_p;
  logic submit_p;

  btn_edge u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (start),
    .pulse_o (start_p)
  );

  btn_edge u_submit_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (submit),
    .pulse_o (submit_p)
  );

  state_e             state_q, state_d;
  logic [1:0]         round_q, round_d;
  logic [1:0]         score_q, score_d;
  logic [2:0]         tries_q, tries_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [9:0]         sw_q;
  logic [9:0]         sol_q, sol_d;
  logic               res_ok_q, res_ok_d;
  logic               res_bad_q, res_bad_d;
  logic               win_q, win_d;
  logic               chk_en_q;
  logic [1:0]         tc_q;
  logic               busy_q;
  logic               over_q;
  logic               pass;

  assign pass = check_passed(chk_correct, chk_wrong, chk_finish);

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    score_d   = score_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    sol_d     = sol_q;
    res_ok_d  = res_ok_q;
    res_bad_d = res_bad_q;
    win_d     = win_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_p) begin
          state_d = LOAD;
          round_d = 2'd0;
          score_d = 2'd0;
          tries_d = TRIES_INIT;
          win_d   = 1'b0;
        end
      end

      LOAD: begin
        timer_d   = '0;
        res_ok_d  = 1'b0;
        res_bad_d = 1'b0;
        state_d   = WAIT_SUB;
      end

      WAIT_SUB: begin
        timer_d = timer_q + 1'b1;
        // A submit edge on the last timer cycle still counts as a real check.
        if (submit_p) begin
          sol_d   = sw_q;
          state_d = CHECK;
        end else if (timer_q == TIMER_LAST) begin
          res_ok_d  = 1'b0;
          res_bad_d = 1'b1;
          hold_d    = '0;
          state_d   = RESULT;
        end
      end

      CHECK: begin
        res_ok_d  = pass;
        res_bad_d = ~pass;
        hold_d    = '0;
        state_d   = RESULT;
      end

      RESULT: begin
        if (hold_q == HOLD_LAST) begin
          if (res_ok_q) begin
            if (score_q != 2'd3) score_d = score_q + 2'd1;
            if (round_q == LAST_ROUND) begin
              win_d   = 1'b1;
              state_d = DONE;
            end else begin
              round_d = round_q + 2'd1;
              state_d = LOAD;
            end
          end else begin
            if (tries_q != 3'd0) tries_d = tries_q - 3'd1;
            state_d = (tries_q <= 3'd1) ? DONE : LOAD;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      round_q   <= 2'd0;
      score_q   <= 2'd0;
      tries_q   <= TRIES_INIT;
      timer_q   <= '0;
      hold_q    <= '0;
      sw_q      <= 10'd0;
      sol_q     <= 10'd0;
      res_ok_q  <= 1'b0;
      res_bad_q <= 1'b0;
      win_q     <= 1'b0;
      chk_en_q  <= 1'b0;
      tc_q      <= TC_NONE;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      score_q   <= score_d;
      tries_q   <= tries_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      sw_q      <= switches;
      sol_q     <= sol_d;
      res_ok_q  <= res_ok_d;
      res_bad_q <= res_bad_d;
      win_q     <= win_d;
      chk_en_q  <= (state_d == CHECK);
      tc_q      <= (state_d == IDLE) ? TC_NONE : round_d + 2'd1;
      busy_q    <= (state_d != IDLE) && (state_d != DONE);
      over_q    <= (state_d == DONE);
    end
  end

  assign chk_en       = chk_en_q;
  assign chk_testcase = tc_q;
  assign chk_sol      = sol_q;
  assign round_idx    = round_q;
  assign score        = score_q;
  assign tries_left   = tries_q;
  assign busy         = busy_q;
  assign res_ok       = res_ok_q;
  assign res_bad      = res_bad_q;
  assign game_over    = over_q;
  assign win          = win_q;

endmodule

// File: tb/tb_puzzle_round_ctrl.sv
// Directed bench for puzzle_round_ctrl: table of attempts plus hand-written
// timeout, handshake and reset sequences.
module tb_puzzle_round_ctrl;
  import puzzle_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [9:0] switches = 10'd0;
  logic       chk_correct, chk_wrong, chk_finish;
  logic       chk_en;
  logic [1:0] chk_testcase;
  logic [9:0] chk_sol;
  logic [1:0] round_idx, score;
  logic [2:0] tries_left;
  logic       busy, res_ok, res_bad, game_over, win;
  logic [1:0] chk_mode = 2'd0;

  int checks = 0;
  int failures = 0;

  puzzle_round_ctrl #(
    .NUM_ROUNDS (3),
    .MAX_TRIES  (3),
    .TIME_LIMIT (8),
    .RESULT_HOLD(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .submit      (submit),
    .switches    (switches),
    .chk_correct (chk_correct),
    .chk_wrong   (chk_wrong),
    .chk_finish  (chk_finish),
    .chk_en      (chk_en),
    .chk_testcase(chk_testcase),
    .chk_sol     (chk_sol),
    .round_idx   (round_idx),
    .score       (score),
    .tries_left  (tries_left),
    .busy        (busy),
    .res_ok      (res_ok),
    .res_bad     (res_bad),
    .game_over   (game_over),
    .win         (win)
  );

  always #5 clk = ~clk;

  // Checker model; mode 1 raises correct and wrong together, mode 2 drops finish.
  always_comb begin
    logic good;
    good        = (chk_sol == golden_sol(chk_testcase));
    chk_correct = good;
    chk_wrong   = ~good;
    chk_finish  = 1'b1;
    if (chk_mode == 2'd1) chk_wrong = 1'b1;
    if (chk_mode == 2'd2) chk_finish = 1'b0;
  end

  typedef struct {
    logic       new_game;
    logic [1:0] mode;
    logic [9:0] sw;
    logic [1:0] tc;
    logic       ok;
    logic       bad;
    logic [1:0] rnd;
    logic [1:0] sc;
    logic [2:0] tries;
    logic       over;
    logic       win;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_chk_en"}, chk_en, 0);
    check({tag, "_tc"}, chk_testcase, 0);
    check({tag, "_sol"}, chk_sol, 0);
    check({tag, "_round"}, round_idx, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_tries"}, tries_left, 3);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_ok"}, res_ok, 0);
    check({tag, "_res_bad"}, res_bad, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_win"}, win, 0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d", i);
    if (v.new_game) start_game();
    chk_mode = v.mode;
    switches = v.sw;
    submit   = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check({p, "_chk_en"}, chk_en, 1);
    check({p, "_tc"}, chk_testcase, v.tc);
    check({p, "_sol"}, chk_sol, v.sw);
    tick();
    check({p, "_res_ok"}, res_ok, v.ok);
    check({p, "_res_bad"}, res_bad, v.bad);
    chk_mode = 2'd0;
    repeat (4) tick();
    check({p, "_round"}, round_idx, v.rnd);
    check({p, "_score"}, score, v.sc);
    check({p, "_tries"}, tries_left, v.tries);
    check({p, "_over"}, game_over, v.over);
    check({p, "_win"}, win, v.win);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int en_at;
    logic [9:0] sol_seen;

    vecs[0] = '{1'b1, 2'd0, SOL_TC1, 2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 3'd3, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, SOL_TC2, 2'd2, 1'b1, 1'b0, 2'd2, 2'd2, 3'd3, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, SOL_TC3, 2'd3, 1'b1, 1'b0, 2'd2, 2'd3, 3'd3, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 2'd0, 10'h000, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, SOL_TC1, 2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 3'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd1, SOL_TC2, 2'd2, 1'b0, 1'b1, 2'd1, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'd2, SOL_TC2, 2'd2, 1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 2'd0, 10'h3FF, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 10'h3FF, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 2'd0, 10'h3FF, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0};

    #1 reset_n = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Loss state is frozen and ignores submit
    check("done_over", game_over, 1);
    check("done_tries", tries_left, 0);
    en_cnt = 0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    repeat (4) begin
      tick();
      if (chk_en) en_cnt++;
    end
    check("done_submit_chk_en", en_cnt, 0);
    check("done_submit_over", game_over, 1);

    // Restart after loss
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_busy", busy, 1);
    check("restart_over", game_over, 0);
    check("restart_tries", tries_left, 3);
    check("restart_score", score, 0);
    check("restart_tc", chk_testcase, 1);

    // Timeout: no submit, res_bad 8 cycles after WAIT_SUB entry
    tick();
    en_cnt = 0;
    repeat (7) begin
      tick();
      if (chk_en) en_cnt++;
    end
    check("timeout_early_res_bad", res_bad, 0);
    tick();
    check("timeout_res_bad", res_bad, 1);
    check("timeout_res_ok", res_ok, 0);
    check("timeout_no_chk_en", en_cnt, 0);
    repeat (4) tick();
    check("timeout_tries", tries_left, 2);
    check("timeout_round", round_idx, 0);

    // Submit edge landing on the timeout cycle is a real check
    tick();
    repeat (6) tick();
    switches = SOL_TC1;
    submit   = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check("edge_timeout_chk_en", chk_en, 1);
    check("edge_timeout_res_bad", res_bad, 0);
    tick();
    check("edge_timeout_res_ok", res_ok, 1);
    repeat (4) tick();
    check("edge_timeout_round", round_idx, 1);
    check("edge_timeout_score", score, 1);
    check("edge_timeout_tries", tries_left, 2);

    // Held submit gives one chk_en, 2 cycles after the rise, with captured switches
    tick();
    switches = SOL_TC2;
    submit   = 1'b1;
    en_cnt   = 0;
    en_at    = -1;
    sol_seen = 10'd0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) switches = 10'h000;
      if (chk_en) begin
        en_cnt++;
        en_at    = c;
        sol_seen = chk_sol;
      end
    end
    check("hold_chk_en_count", en_cnt, 1);
    check("hold_chk_en_cycle", en_at, 2);
    check("hold_chk_sol", sol_seen, SOL_TC2);
    submit = 1'b0;

    // Reset asserted asynchronously while chk_en is high
    tick();
    submit = 1'b1;
    tick();
    tick();
    check("pre_reset_chk_en", chk_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    submit = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_tc", chk_testcase, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("resume_busy", busy, 1);
    check("resume_tc", chk_testcase, 1);
    check("resume_tries", tries_left, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
